// File: rtl/hazard_control_unit_pkg.sv
// hazard_control_unit_pkg: state encodings, control bundle and register-number width shared by hazard and forwarding logic
package hazard_control_unit_pkg;
    localparam int REG_W = 5;
    typedef enum logic [1:0] {
        RUN        = 2'b00,
        LOAD_STALL = 2'b01,
        FLUSH      = 2'b10,
        MEM_WAIT   = 2'b11
    } state_e;
    typedef struct packed {
        logic pc_write;
        logic ifid_write;
        logic idex_write;
        logic ifid_flush;
        logic idex_bubble;
        logic exmem_hold;
    } ctrl_t;
    localparam ctrl_t CTRL_IDLE  = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    localparam ctrl_t CTRL_MEM   = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    localparam ctrl_t CTRL_FLUSH = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    localparam ctrl_t CTRL_LOAD  = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
endpackage

// File: rtl/hazard_control_unit_load_use.sv
// load_use_detect: flags a load in ID/EX whose destination feeds a source of the IF/ID instruction
module load_use_detect
    import hazard_control_unit_pkg::*;
(
    input  logic             idex_mem_read,
    input  logic [REG_W-1:0] idex_rt,
    input  logic [REG_W-1:0] ifid_rs,
    input  logic [REG_W-1:0] ifid_rt,
    output logic             hazard
);
    assign hazard = idex_mem_read && (idex_rt != '0) && ((idex_rt == ifid_rs) || (idex_rt == ifid_rt));
endmodule

// File: rtl/hazard_control_unit.sv
// hazard_control_unit: pipeline stall/flush control for memory wait, taken branches and load-use hazards
module hazard_control_unit
    import hazard_control_unit_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             IDEX_MemRead,
    input  logic [REG_W-1:0] IDEX_Rt,
    input  logic [REG_W-1:0] IFID_Rs,
    input  logic [REG_W-1:0] IFID_Rt,
    input  logic             branch_taken,
    input  logic             dmem_req,
    input  logic             dmem_ready,
    output logic             PC_Write,
    output logic             IFID_Write,
    output logic             IDEX_Write,
    output logic             IFID_Flush,
    output logic             IDEX_Bubble,
    output logic             EXMEM_Hold,
    output logic [1:0]       state,
    output logic [CNT_W-1:0] stall_count
);
    state_e           state_q, state_d;
    logic [CNT_W-1:0] stall_count_q, stall_count_d;
    ctrl_t            ctrl;
    logic             hazard;
    logic             mem_wait;

    load_use_detect u_load_use_detect (
        .idex_mem_read(IDEX_MemRead),
        .idex_rt      (IDEX_Rt),
        .ifid_rs      (IFID_Rs),
        .ifid_rt      (IFID_Rt),
        .hazard       (hazard)
    );

    // MEM_WAIT holds on dmem_ready alone; elsewhere a fresh wait needs an active request
    assign mem_wait = (dmem_req && !dmem_ready) || (state_q == MEM_WAIT && !dmem_ready);

    always_comb begin
        ctrl    = CTRL_IDLE;
        state_d = RUN;
        if (!rst_n) begin
            ctrl    = CTRL_IDLE;
            state_d = RUN;
        end else if (mem_wait) begin
            ctrl    = CTRL_MEM;
            state_d = MEM_WAIT;
        end else if (branch_taken && (state_q == RUN || state_q == LOAD_STALL)) begin
            ctrl    = CTRL_FLUSH;
            state_d = FLUSH;
        end else if (hazard && state_q == RUN) begin
            ctrl    = CTRL_LOAD;
            state_d = LOAD_STALL;
        end
        stall_count_d = (!ctrl.pc_write && stall_count_q != {CNT_W{1'b1}}) ? stall_count_q + CNT_W'(1) : stall_count_q;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q       <= RUN;
            stall_count_q <= '0;
        end else begin
            state_q       <= state_d;
            stall_count_q <= stall_count_d;
        end
    end

    assign PC_Write    = ctrl.pc_write;
    assign IFID_Write  = ctrl.ifid_write;
    assign IDEX_Write  = ctrl.idex_write;
    assign IFID_Flush  = ctrl.ifid_flush;
    assign IDEX_Bubble = ctrl.idex_bubble;
    assign EXMEM_Hold  = ctrl.exmem_hold;
    assign state       = state_q;
    assign stall_count = stall_count_q;
endmodule
